nios_sysid_checker: RTL and testbench

Avalon-MM read master that interrogates the system-ID slave at boot or on request. Reads word 0 (system ID) and word 1 (build timestamp), compares them with expected values, and reports pass or fail to the board-level status logic. Sits beside the Nios II system in the wrapper. Lets the hardware flag an FPGA image/software mismatch without CPU involvement.

---
 rtl/nios_sysid_pkg.sv | 34 +++
 rtl/nios_sysid_checker_avm_read_timer.sv | 30 +++
 rtl/nios_sysid_checker.sv | 168 ++++++++++++++++
 tb/tb_nios_sysid_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package nios_sysid_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RETRY_W = 2;
  localparam int unsigned FAIL_W  = 2;

  // Checker states (plain constants so the encoding stays visible)
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t RD_ID  = 3'd1;
  localparam state_t RD_TS  = 3'd2;
  localparam state_t RETRY  = 3'd3;
  localparam state_t CHECK  = 3'd4;
  localparam state_t FINISH = 3'd5;

  // Result codes reported on fail_code
  typedef logic [FAIL_W-1:0] fail_code_t;
  localparam fail_code_t FAIL_NONE    = 2'd0;
  localparam fail_code_t FAIL_ID      = 2'd1;
  localparam fail_code_t FAIL_TS      = 2'd2;
  localparam fail_code_t FAIL_TIMEOUT = 2'd3;

  // Word addresses inside the sysid slave
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // True in the states that own an Avalon read
  function automatic logic is_read_state(input state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/nios_sysid_checker_avm_read_timer.sv
// Loadable stall counter for one Avalon read; expired_c flags the limit.
module avm_read_timer
  import nios_sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             inc,
  output logic             expired_c
);

  logic [CNT_W-1:0] count_q;

  // Load wins over increment; the count never wraps past the limit
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (inc && !expired_c) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_c = (count_q == CNT_W'(LIMIT));

endmodule

// File: rtl/nios_sysid_checker.sv
// Avalon-MM read master that checks the sysid slave (ID word and build
// timestamp) and reports pass/fail. Optional macro SYSID_CHECK_AUTOSTART_EN
// launches one check on the first cycle after reset is released.
module nios_sysid_checker
  import nios_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1539281382,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               avm_read_d, avm_address_d;
  logic               busy_d, done_d, pass_d;
  fail_code_t         fail_code_d;
  logic [31:0]        id_d, ts_d;
  logic               tmr_load, tmr_inc, tmr_expired;
  logic               start_int;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_pend_q;

  // One-shot start request, armed while reset is held
  always_ff @(posedge clock) begin
    if (reset) begin
      auto_pend_q <= 1'b1;
    end else begin
      auto_pend_q <= 1'b0;
    end
  end

  assign start_int = start | auto_pend_q;
`else
  assign start_int = start;
`endif

  avm_read_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value ('0),
    .inc        (tmr_inc),
    .expired_c  (tmr_expired)
  );

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      avm_read    <= avm_read_d;
      avm_address <= avm_address_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      fail_code   <= fail_code_d;
      id_value    <= id_d;
      ts_value    <= ts_d;
    end
  end

  // Next state, captured words, result and bus strobes
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    pass_d      = pass;
    fail_code_d = fail_code;
    id_d        = id_value;
    ts_d        = ts_value;
    tmr_load    = 1'b0;
    tmr_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_int) begin
          state_d     = RD_ID;
          retry_d     = '0;
          pass_d      = 1'b0;
          fail_code_d = FAIL_NONE;
          tmr_load    = 1'b1;
        end
      end

      RD_ID, RD_TS: begin
        // A low waitrequest completes the read even at the stall limit
        if (!avm_waitrequest) begin
          tmr_load = 1'b1;
          if (state_q == RD_ID) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
          end else begin
            ts_d    = avm_readdata;
            state_d = CHECK;
          end
        end else if (tmr_expired) begin
          if (retry_q < RETRY_W'(MAX_RETRIES)) begin
            retry_d = retry_q + 1'b1;
            state_d = RETRY;
          end else begin
            fail_code_d = FAIL_TIMEOUT;
            state_d     = FINISH;
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end

      RETRY: begin
        state_d  = RD_ID;
        tmr_load = 1'b1;
      end

      CHECK: begin
        if (id_value != EXPECTED_ID) begin
          fail_code_d = FAIL_ID;
        end else if (ts_value != EXPECTED_TIMESTAMP) begin
          fail_code_d = FAIL_TS;
        end else begin
          pass_d = 1'b1;
        end
        state_d = FINISH;
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    avm_read_d    = is_read_state(state_d);
    avm_address_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
    busy_d        = (state_d != IDLE) && (state_d != FINISH);
    done_d        = (state_d == FINISH);
  end

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Scoreboard bench for nios_sysid_checker with a configurable sysid slave.
module tb_nios_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1539281382;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b1;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value, ts_value;

  nios_sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pass;
    logic [1:0]  fc;
    logic [31:0] id;
    logic [31:0] ts;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [31:0] cfg_id = EXP_ID;
  logic [31:0] cfg_ts = EXP_TS;
  int          cfg_wait = 0;
  bit          cfg_stuck = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] last_id = 32'd0;
  logic [31:0] last_ts = 32'd0;

  logic last_read = 1'b0;
  logic last_addr = 1'b0;
  int   hi_len = 0;
  int   stall_viol = 0;
  int   rises[$];
  int   runs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clock) cyc++;

  // Sysid slave: cfg_wait stall cycles per read, or stalls forever
  always @(negedge clock) begin
    if (avm_read && !cfg_stuck) begin
      if (stall_cnt < cfg_wait) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt = 0;
        avm_readdata = avm_address ? cfg_ts : cfg_id;
      end
    end else begin
      avm_waitrequest = 1'b1;
      stall_cnt = 0;
    end
  end

  // Bus watcher: stability while stalled, read strobe rises and run lengths
  always @(posedge clock) begin
    #1;
    if (last_read && avm_waitrequest && !reset && !cfg_stuck)
      if (!avm_read || avm_address != last_addr) stall_viol++;
    if (avm_read && !last_read) rises.push_back(cyc);
    if (avm_read) hi_len++;
    else if (last_read) begin
      runs.push_back(hi_len);
      hi_len = 0;
    end
    last_read = avm_read;
    last_addr = avm_address;
  end

  // Result monitor: pops the scoreboard on every done pulse
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("pass", pass, mon_e.pass);
        check("fail_code", fail_code, mon_e.fc);
        check("id_value", id_value, mon_e.id);
        check("ts_value", ts_value, mon_e.ts);
        check("done_latency", cyc - mon_e.t0, mon_e.lat);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic issue(input logic [31:0] id, input logic [31:0] ts, input int w,
                       input bit stuck, input logic ep, input logic [1:0] efc, input int lat);
    exp_t e;
    cfg_id = id; cfg_ts = ts; cfg_wait = w; cfg_stuck = stuck;
    if (!stuck) begin
      last_id = id;
      last_ts = ts;
    end
    e.pass = ep; e.fc = efc; e.id = last_id; e.ts = last_ts; e.t0 = cyc; e.lat = lat;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avm_read"}, avm_read, 0);
    check({tag, "_avm_address"}, avm_address, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail_code"}, fail_code, 0);
    check({tag, "_id_value"}, id_value, 0);
    check({tag, "_ts_value"}, ts_value, 0);
  endtask

  task automatic release_reset();
    last_id = 32'd0;
    last_ts = 32'd0;
`ifdef SYSID_CHECK_AUTOSTART_EN
    begin
      exp_t e;
      cfg_id = EXP_ID; cfg_ts = EXP_TS; cfg_wait = 0; cfg_stuck = 1'b0;
      last_id = EXP_ID; last_ts = EXP_TS;
      e.pass = 1'b1; e.fc = 2'd0; e.id = EXP_ID; e.ts = EXP_TS; e.t0 = cyc; e.lat = 4;
      sbq.push_back(e);
      reset = 1'b0;
      wait_done(50, "autostart");
    end
`else
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("no_autostart_busy", busy, 0);
    check("no_autostart_read", avm_read, 0);
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    release_reset();

    // Zero wait states: done four cycles after start
    issue(EXP_ID, EXP_TS, 0, 0, 1'b1, 2'd0, 4);
    wait_done(50, "zero_wait");

    // Five wait states per read, bus held steady while stalled
    stall_viol = 0;
    issue(EXP_ID, EXP_TS, 5, 0, 1'b1, 2'd0, 14);
    wait_done(50, "wait5");
    check("stall_stability_violations", stall_viol, 0);

    // ID mismatch: reported, never retried
    rises.delete();
    issue(32'h1, EXP_TS, 0, 0, 1'b0, 2'd1, 4);
    wait_done(50, "id_mismatch");
    check("id_mismatch_read_bursts", rises.size(), 1);

    // Timestamp mismatch
    issue(EXP_ID, 32'd1539281381, 0, 0, 1'b0, 2'd2, 4);
    wait_done(50, "ts_mismatch");

    // Read completing on the last allowed stall cycle is a success
    issue(EXP_ID, EXP_TS, 255, 0, 1'b1, 2'd0, 514);
    wait_done(600, "stall_limit");

    // Stuck slave: four attempts, then timeout; a start while busy is ignored
    rises.delete();
    runs.delete();
    issue(EXP_ID, EXP_TS, 0, 1, 1'b0, 2'd3, 1028);
    repeat (100) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(1100, "timeout");
    check("timeout_attempts", rises.size(), 4);
    check("timeout_runs", runs.size(), 4);
    for (int i = 0; i < runs.size(); i++) check("timeout_run_len", runs[i], 256);
    for (int i = 1; i < rises.size(); i++) check("timeout_rise_gap", rises[i] - rises[i-1], 257);
    cfg_stuck = 1'b0;

    // Reset while reading the timestamp word
    cfg_id = 32'h0000_DEAD; cfg_ts = EXP_TS; cfg_wait = 5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(avm_read && avm_address) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("reached_rd_ts", avm_address, 1);
    check("id_captured_before_reset", id_value, 32'h0000_DEAD);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("midread_reset");
    @(negedge clock);
    release_reset();

    repeat (4) @(negedge clock);
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
